hdmi_tx_int_conditioner: RTL and testbench
==========================================

# hdmi_tx_int_conditioner

Conditions the raw, asynchronous active-low interrupt pin of the HDMI transmitter before it reaches the interrupt PIO's `in_port`. It synchronises the pin, rejects glitches shorter than a programmable qualification time, and drives a clean, level-stable `int_n_out`. It also counts qualified assertions and rejected glitches, and exposes both counts plus control and status through a small Avalon-MM slave on the HDMI Qsys bus.

## Interface
- `FILTER_CYCLES`, 16: consecutive clk cycles a new level must persist before `int_n_out` follows it; legal range 1..65535.
- `CNT_W`, 16: width of the event and glitch counters; legal range 1..32.

- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `int_n_pin`  in  1  raw interrupt pin from the transmitter; asynchronous, active-low.
- `address`  in  2  Avalon-MM word address.
- `chipselect`  in  1  Avalon-MM select.
- `write_n`  in  1  Avalon-MM write strobe, active-low.
- `writedata`  in  32  Avalon-MM write data.
- `readdata`  out  32  Avalon-MM read data; registered.
- `int_n_out`  out  1  filtered level; feeds the interrupt PIO `in_port`.
- `event_pulse`  out  1  one-cycle strobe on each qualified assertion.

## Operation
- **Synchroniser:** two flops `s1` and `s2`, both reset to 1. Only `s2` is used downstream.
- **Filter FSM** (4 states), with a counter `qcnt` of width clog2(FILTER_CYCLES+1):
  - `HIGH`: `int_n_out`=1. If `s2`=0, go to `QUAL_LOW` with `qcnt`=1.
  - `QUAL_LOW`: `int_n_out`=1.
    - If `s2`=1: go to `HIGH`, increment the glitch counter.
    - Else if `qcnt`==FILTER_CYCLES: go to `LOW`, pulse `event_pulse`, increment the event counter.
    - Else: `qcnt`++.
  - `LOW`: `int_n_out`=0. If `s2`=1, go to `QUAL_HIGH` with `qcnt`=1.
  - `QUAL_HIGH`: `int_n_out`=0. Mirror of `QUAL_LOW`.
    - If `s2`=0: return to `LOW`, increment the glitch counter.
    - If `qcnt`==FILTER_CYCLES: go to `HIGH`. No event is counted.
  - FILTER_CYCLES=1: the 1-cycle check in a QUAL state still applies. A level must be present in `s2` for 1 cycle beyond the entry cycle.
- **Control** (`enable`, `bypass`):
  - `enable`=0: FSM forced to `HIGH`, `int_n_out`=1, counters frozen, `event_pulse`=0.
  - `bypass`=1 and `enable`=1: `int_n_out`=`s2` directly. FSM still runs and counts normally.
- **Counters:** saturate at 2^CNT_W-1 and do not wrap.
- **Register map** (word addresses):
  - 0 status, read-only: bit0 `int_n_out`, bit1 `s2`, bit2 FSM in a QUAL state, bit3 event counter saturated.
  - 1 control, R/W: bit0 `enable` (reset 1), bit1 `bypass` (reset 0). Other bits read 0.
  - 2 event count, zero-extended. Any write clears it.
  - 3 glitch count, zero-extended. Any write clears it.
- **Write rules:** a write happens when `chipselect`=1 and `write_n`=0, and takes effect at the next clk edge. Write data bits above the defined fields are ignored.
- **Clear vs. increment:** if a clear and an increment of the same counter occur in the same cycle, the counter becomes 1.

## Timing
- **Reset values:** `readdata`=0, `int_n_out`=1, `event_pulse`=0. FSM in `HIGH`, counters 0, `enable`=1, `bypass`=0.
- **Read:** `readdata` updates every clk edge from `address`. One-cycle latency, with no dependency on `chipselect`, matching the PIO slave.
- **Assertion latency:** if `int_n_pin` is first sampled low at edge E and stays low, `int_n_out` falls after edge E+2+FILTER_CYCLES. `event_pulse` is high for exactly the cycle following that edge.
- **Deassertion latency:** the same, E+2+FILTER_CYCLES, with no pulse.
- **Glitch rejection:** a low pulse reaching `s2` for fewer than FILTER_CYCLES+1 consecutive cycles never changes `int_n_out`. It increments the glitch count by 1.
- **Enable transitions:** clearing `enable` mid-qualification aborts with no glitch count. Re-enabling starts from `HIGH`, so an already-low pin asserts after FILTER_CYCLES+1 cycles.
- **Reset mid-operation:** reset asserted at any point returns all state to reset values asynchronously.

## Test plan
- **Reset:** apply reset with the pin held low, then release → `int_n_out`=1 during reset. `int_n_out` falls exactly 2+16 edges after the first sampled-low edge; `event_pulse` 1 cycle; reg2 reads 1.
- **Glitch rejection:** FILTER_CYCLES=16, 10-cycle low pulse → `int_n_out` stays 1, reg3=1, reg2=0. Then a 17-cycle low → asserts, reg2=1.
- **Saturation and clear:** CNT_W=2, 5 qualified assertions → reg2=3 and status bit3=1. Write reg2 → 0. Write reg2 in the same cycle as a qualifying edge → 1.
- **Bypass:** `bypass`=1, 3-cycle low pulse → `int_n_out` low for 3 cycles, delayed 2; reg3 increments.
- **Enable:** `enable`=0 with pin toggling → `int_n_out`=1, counters unchanged. Re-enable with pin low → assert after FILTER_CYCLES+1 cycles.
- **Register access:** write 0xFFFFFFFF to reg1 → reads 0x3. Reads of all addresses return data 1 cycle after the address is presented.

Source files
------------

// File: rtl/hdmi_tx_int_conditioner.sv
// rtl/hdmi_tx_int_conditioner.sv - HDMI TX interrupt pin synchroniser, glitch filter, counters and Avalon-MM CSRs
`timescale 1ns/1ps
module hdmi_tx_int_conditioner #(
    parameter int FILTER_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        int_n_pin,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        int_n_out,
    output logic        event_pulse
);

    localparam int              QW   = $clog2(FILTER_CYCLES + 1);
    localparam logic [QW-1:0]   QMAX = QW'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_HIGH      = 2'd0,
        ST_QUAL_LOW  = 2'd1,
        ST_LOW       = 2'd2,
        ST_QUAL_HIGH = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [QW-1:0]     qcnt;
    logic [QW-1:0]     qcnt_nxt;
    logic              ev_inc;
    logic              gl_inc;
    logic              pulse_q;
    logic              s1;
    logic              s2;
    logic              enable;
    logic              bypass;
    logic [CNT_W-1:0]  ev_cnt;
    logic [CNT_W-1:0]  gl_cnt;
    logic              wr_en;
    logic              filt_n;
    logic              in_qual;
    logic              ev_sat;
    logic              unused_wd;

    assign wr_en     = chipselect & ~write_n;
    // The filtered level is high while settled high or qualifying a fall.
    assign filt_n    = (state == ST_HIGH) || (state == ST_QUAL_LOW);
    assign in_qual   = (state == ST_QUAL_LOW) || (state == ST_QUAL_HIGH);
    assign ev_sat    = (ev_cnt == CMAX);
    assign int_n_out = !enable ? 1'b1 : (bypass ? s2 : filt_n);
    assign event_pulse = pulse_q & enable;
    assign unused_wd = ^writedata[31:2];

    // Saturating counter step; a clear and an increment together leave 1.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic clr, input logic inc);
        if (clr)
            return inc ? CNT_W'(1) : '0;
        else if (inc && (cur != CMAX))
            return cur + CNT_W'(1);
        else
            return cur;
    endfunction

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= int_n_pin;
            s2 <= s1;
        end
    end

    // Filter state, qualification counter and event strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_HIGH;
            qcnt    <= '0;
            pulse_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            qcnt    <= qcnt_nxt;
            pulse_q <= ev_inc;
        end
    end

    // Filter next-state: a new level must hold for the full qualification window.
    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        ev_inc    = 1'b0;
        gl_inc    = 1'b0;
        if (!enable) begin
            state_nxt = ST_HIGH;
            qcnt_nxt  = '0;
        end else begin
            case (state)
                ST_HIGH: begin
                    if (!s2) begin
                        state_nxt = ST_QUAL_LOW;
                        qcnt_nxt  = QW'(1);
                    end
                end
                ST_QUAL_LOW: begin
                    if (s2) begin
                        state_nxt = ST_HIGH;
                        qcnt_nxt  = '0;
                        gl_inc    = 1'b1;
                    end else if (qcnt == QMAX) begin
                        state_nxt = ST_LOW;
                        qcnt_nxt  = '0;
                        ev_inc    = 1'b1;
                    end else begin
                        qcnt_nxt  = qcnt + QW'(1);
                    end
                end
                ST_LOW: begin
                    if (s2) begin
                        state_nxt = ST_QUAL_HIGH;
                        qcnt_nxt  = QW'(1);
                    end
                end
                ST_QUAL_HIGH: begin
                    if (!s2) begin
                        state_nxt = ST_LOW;
                        qcnt_nxt  = '0;
                        gl_inc    = 1'b1;
                    end else if (qcnt == QMAX) begin
                        state_nxt = ST_HIGH;
                        qcnt_nxt  = '0;
                    end else begin
                        qcnt_nxt  = qcnt + QW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_HIGH;
                    qcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Event and glitch counters: write-to-clear, saturating increments.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ev_cnt <= '0;
            gl_cnt <= '0;
        end else begin
            ev_cnt <= cnt_next(ev_cnt, wr_en && (address == 2'd2), ev_inc);
            gl_cnt <= cnt_next(gl_cnt, wr_en && (address == 2'd3), gl_inc);
        end
    end

    // Control register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable <= 1'b1;
            bypass <= 1'b0;
        end else if (wr_en && (address == 2'd1)) begin
            enable <= writedata[0];
            bypass <= writedata[1];
        end
    end

    // Registered read mux, updated every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= {28'd0, ev_sat, in_qual, s2, int_n_out};
                2'd1:    readdata <= {30'd0, bypass, enable};
                2'd2:    readdata <= 32'(ev_cnt);
                default: readdata <= 32'(gl_cnt);
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_tx_int_conditioner.sv
// tb/tb_hdmi_tx_int_conditioner.sv - scoreboard bench for hdmi_tx_int_conditioner
`timescale 1ns/1ps
module tb_hdmi_tx_int_conditioner;

    localparam int FC    = 16;
    localparam int CW    = 2;
    localparam int CMAXI = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        int_n_pin;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        int_n_out;
    logic        event_pulse;

    always #5 clk = ~clk;

    hdmi_tx_int_conditioner #(.FILTER_CYCLES(FC), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .int_n_pin   (int_n_pin),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .int_n_out   (int_n_out),
        .event_pulse (event_pulse)
    );

    typedef struct {
        logic        o;
        logic        p;
        logic [31:0] rd;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: filtered level changes once s2 has disagreed with it
    // for FC+1 consecutive enabled samples; a shorter disagreement is a glitch.
    bit m_s1, m_s2, m_en, m_byp, m_filt, m_pulse;
    int m_run, m_ev, m_gl;

    // Directed observation counters.
    int lo_cnt, pulse_cnt, step_no, first_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_out();
        return !m_en ? 1'b1 : (m_byp ? m_s2 : m_filt);
    endfunction

    task automatic model_reset();
        m_s1 = 1; m_s2 = 1; m_en = 1; m_byp = 0; m_filt = 1; m_pulse = 0;
        m_run = 0; m_ev = 0; m_gl = 0;
    endtask

    // One clock: drive inputs, advance the model across the edge, queue expectation.
    task automatic step(input bit pin, input bit cs, input bit wn,
                        input logic [1:0] addr, input logic [31:0] wd);
        exp_t e;
        bit   wr, inc_e, inc_g;
        logic [31:0] rd;
        int_n_pin  = pin;
        chipselect = cs;
        write_n    = wn;
        address    = addr;
        writedata  = wd;
        @(posedge clk);
        #1;
        wr = cs && !wn;
        case (addr)
            2'd0: rd = {28'd0, 1'(m_ev == CMAXI), 1'(m_run > 0), 1'(m_s2), 1'(m_out())};
            2'd1: rd = {30'd0, 1'(m_byp), 1'(m_en)};
            2'd2: rd = 32'(m_ev);
            default: rd = 32'(m_gl);
        endcase
        inc_e = 0;
        inc_g = 0;
        if (m_en) begin
            if (m_s2 != m_filt) begin
                m_run++;
                if (m_run == FC + 1) begin
                    m_filt = m_s2;
                    m_run  = 0;
                    if (m_s2 == 0) inc_e = 1;
                end
            end else begin
                if (m_run > 0) inc_g = 1;
                m_run = 0;
            end
        end else begin
            m_filt = 1;
            m_run  = 0;
        end
        m_pulse = inc_e;
        if (wr && addr == 2'd2) m_ev = inc_e ? 1 : 0;
        else if (inc_e && m_ev < CMAXI) m_ev++;
        if (wr && addr == 2'd3) m_gl = inc_g ? 1 : 0;
        else if (inc_g && m_gl < CMAXI) m_gl++;
        if (wr && addr == 2'd1) begin
            m_en  = wd[0];
            m_byp = wd[1];
        end
        m_s2 = m_s1;
        m_s1 = pin;
        e.o  = m_out();
        e.p  = m_pulse & m_en;
        e.rd = rd;
        sbq.push_back(e);
        step_no++;
        if (int_n_out == 1'b0) begin
            lo_cnt++;
            if (first_lo == 0) first_lo = step_no;
        end
        if (event_pulse) pulse_cnt++;
    endtask

    task automatic idle(input bit pin, input int n, input logic [1:0] addr);
        repeat (n) step(pin, 1'b0, 1'b1, addr, 32'd0);
    endtask

    task automatic wr_reg(input bit pin, input logic [1:0] addr, input logic [31:0] d);
        step(pin, 1'b1, 1'b0, addr, d);
    endtask

    task automatic clr_obs();
        lo_cnt = 0; pulse_cnt = 0; step_no = 0; first_lo = 0;
    endtask

    task automatic mid_reset();
        #6;
        reset_n = 1'b0;
        #1;
        check("async_reset_out", int_n_out, 1'b1);
        check("async_reset_pulse", event_pulse, 1'b0);
        check("async_reset_rd", readdata, 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold_out", int_n_out, 1'b1);
        reset_n = 1'b1;
        model_reset();
    endtask

    // Monitor: one expectation per cycle, compared away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_int_n_out", int_n_out, e.o);
                check("sb_event_pulse", event_pulse, e.p);
                check("sb_readdata", readdata, e.rd);
            end
        end
    end

    initial begin
        bit pin_lvl;
        int run_left;
        logic [31:0] d;
        logic [1:0]  a;

        // Reset with the pin already low.
        reset_n = 1'b0; int_n_pin = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_out", int_n_out, 1'b1);
        check("reset_pulse", event_pulse, 1'b0);
        check("reset_rd", readdata, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Assertion latency: first low sample is step 1, output falls after step FC+3.
        clr_obs();
        idle(1'b0, 40, 2'd0);
        check("assert_latency", first_lo, FC + 3);
        check("assert_pulse_cnt", pulse_cnt, 1);
        idle(1'b0, 1, 2'd2);
        check("reset_test_reg2", readdata, 32'd1);

        // Deassertion latency, no pulse.
        clr_obs();
        idle(1'b1, 40, 2'd1);
        check("deassert_latency", lo_cnt, FC + 2);
        check("deassert_pulse_cnt", pulse_cnt, 0);
        wr_reg(1'b1, 2'd2, 32'd0);
        wr_reg(1'b1, 2'd3, 32'd0);

        // Glitch rejection, then a just-long-enough low.
        clr_obs();
        idle(1'b0, 10, 2'd0);
        idle(1'b1, 25, 2'd0);
        check("glitch_out_stays_high", lo_cnt, 0);
        idle(1'b1, 1, 2'd3);
        check("glitch_reg3", readdata, 32'd1);
        idle(1'b1, 1, 2'd2);
        check("glitch_reg2", readdata, 32'd0);
        clr_obs();
        idle(1'b0, FC + 1, 2'd0);
        idle(1'b1, 25, 2'd0);
        check("min_qualify_pulse", pulse_cnt, 1);
        idle(1'b1, 1, 2'd2);
        check("min_qualify_reg2", readdata, 32'd1);

        // Saturation and clear.
        repeat (5) begin
            idle(1'b0, 20, 2'd0);
            idle(1'b1, 25, 2'd0);
        end
        idle(1'b1, 1, 2'd2);
        check("sat_reg2", readdata, CMAXI);
        idle(1'b1, 1, 2'd0);
        check("sat_status_bit3", readdata[3], 1'b1);
        wr_reg(1'b1, 2'd2, 32'hdead_beef);
        idle(1'b1, 1, 2'd2);
        check("clear_reg2", readdata, 32'd0);
        for (int j = 1; j <= 25; j++)
            step(1'b0, j == FC + 3, j != FC + 3, (j == FC + 3) ? 2'd2 : 2'd0, 32'd0);
        idle(1'b0, 1, 2'd2);
        check("clear_and_inc_reg2", readdata, 32'd1);
        idle(1'b1, 25, 2'd0);

        // Bypass: short pulse passes through two cycles late, still counted as glitch.
        wr_reg(1'b1, 2'd1, 32'd3);
        wr_reg(1'b1, 2'd3, 32'd0);
        clr_obs();
        idle(1'b0, 3, 2'd0);
        idle(1'b1, 10, 2'd0);
        check("bypass_low_cycles", lo_cnt, 3);
        check("bypass_delay", first_lo, 2);
        idle(1'b1, 1, 2'd3);
        check("bypass_reg3", readdata, 32'd1);
        wr_reg(1'b1, 2'd1, 32'd1);

        // Enable: disabled output holds high while the pin toggles.
        wr_reg(1'b1, 2'd1, 32'd0);
        clr_obs();
        for (int j = 0; j < 40; j++) idle(1'(j / 5 % 2), 1, 2'(j));
        idle(1'b0, 25, 2'd0);
        check("disabled_out_high", lo_cnt, 0);
        wr_reg(1'b0, 2'd1, 32'd1);
        clr_obs();
        idle(1'b0, 25, 2'd0);
        check("reenable_latency", first_lo, FC + 1);
        idle(1'b1, 25, 2'd0);

        // Register access.
        wr_reg(1'b1, 2'd1, 32'hffff_ffff);
        idle(1'b1, 1, 2'd1);
        check("ctrl_masked", readdata, 32'd3);
        wr_reg(1'b1, 2'd1, 32'd1);
        idle(1'b1, 1, 2'd1);
        check("ctrl_restore", readdata, 32'd1);
        step(1'b1, 1'b0, 1'b0, 2'd1, 32'd0);
        idle(1'b1, 1, 2'd1);
        check("no_write_without_cs", readdata, 32'd1);

        // Randomised traffic with occasional asynchronous reset.
        pin_lvl = 1'b1;
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                pin_lvl  = ~pin_lvl;
                run_left = ($urandom_range(0, 1) == 0) ? $urandom_range(FC - 2, FC + 3)
                                                       : $urandom_range(1, 30);
            end
            run_left--;
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd1 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            if ($urandom_range(0, 29) == 0)
                step(pin_lvl, 1'b1, 1'b0, a, d);
            else
                step(pin_lvl, 1'($urandom_range(0, 1)), 1'b1, a, d);
            if (c % 900 == 450) mid_reset();
        end

        @(negedge clk);
        #1;
        check("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
